// File: rtl/text_fetch_pkg.sv
// Shared types and defaults for the character fetch sequencer.
package text_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    PRESENT = 3'd2,
    DWELL   = 3'd3,
    DONE    = 3'd4
  } fetch_state_e;

  localparam logic [7:0] TERM_CHAR_DEF = 8'h00;
  localparam int         DWELL_W_DEF   = 16;

endpackage

// File: rtl/text_fetch_ctrl_dwell_timer.sv
// Loadable down-counter with a pause-able enable; holds at zero.
// Shared with cell-refresh timing, so it carries no sequencer knowledge.
module dwell_timer #(
  parameter int W = 16
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic [W-1:0] o_value,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_value = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/text_fetch_ctrl.sv
// Walks the character ROM from start_addr, presents each character over
// valid/ready and holds a dwell time per cell before fetching the next.
module text_fetch_ctrl
  import text_fetch_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] TERM_CHAR = DATA_W'(TERM_CHAR_DEF),
  parameter int                DWELL_W   = DWELL_W_DEF,
  parameter int                DWELL_CYC = 50000
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              pause,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              char_valid,
  output logic [DATA_W-1:0] char_data,
  input  logic              char_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   char_count
);

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYC);

  fetch_state_e        r_state;
  fetch_state_e        w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W:0]     r_count;
  logic [DWELL_W-1:0]  w_dwell_value;
  logic                w_dwell_zero;
  logic                w_hs;
  logic                w_is_term;
  logic                w_addr_top;
  logic                w_dwell_exit;

  assign w_hs       = (r_state == PRESENT) && char_ready;
  assign w_is_term  = (mem_dout == TERM_CHAR);
  assign w_addr_top = (r_addr == {ADDR_W{1'b1}});
  // Leave on the tick that would take the count to zero, so a cell lasts
  // exactly DWELL_CYC unpaused cycles; a zero load leaves at once.
  assign w_dwell_exit = (r_state == DWELL) &&
                        (w_dwell_zero || ((w_dwell_value == DWELL_W'(1)) && !pause));

  dwell_timer #(.W(DWELL_W)) u_dwell_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_hs),
    .i_load_val (DWELL_LOAD),
    .i_en       ((r_state == DWELL) && !pause),
    .o_value    (w_dwell_value),
    .o_zero     (w_dwell_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = FETCH; else w_next = IDLE;
      FETCH:   if (w_is_term) w_next = DONE; else w_next = PRESENT;
      PRESENT: if (w_hs) w_next = DWELL; else w_next = PRESENT;
      DWELL: begin
        if (w_dwell_exit) begin
          if (w_addr_top) w_next = DONE; else w_next = FETCH;
        end else begin
          w_next = DWELL;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_addr  <= start_addr;
      r_count <= '0;
    end else if ((r_state == FETCH) && !w_is_term) begin
      r_data  <= mem_dout;
    end else if (w_hs) begin
      r_count <= r_count + (ADDR_W+1)'(1);
    end else if (w_dwell_exit && !w_addr_top) begin
      r_addr  <= r_addr + ADDR_W'(1);
    end else begin
      r_addr  <= r_addr;
    end
  end

  assign mem_addr   = r_addr;
  assign char_data  = r_data;
  assign char_count = r_count;
  assign char_valid = (r_state == PRESENT);
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);

endmodule

// File: tb/tb_text_fetch_ctrl.sv
// Randomized bench for text_fetch_ctrl: two instances (dwell 4 and dwell 0)
// share a ROM model and are checked every cycle against a timeline model.
module tb_text_fetch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start_a, start_z;
  logic [7:0] start_addr;
  logic       pause;
  logic       char_ready;
  logic [7:0] rom [256];

  logic [7:0] mem_addr_a, mem_dout_a, data_a;
  logic       valid_a, busy_a, done_a;
  logic [8:0] count_a;
  logic [7:0] mem_addr_z, mem_dout_z, data_z;
  logic       valid_z, busy_z, done_z;
  logic [8:0] count_z;

  logic [7:0] m_addr [2];
  logic [7:0] m_data [2];
  logic [8:0] m_cnt  [2];

  int n_chk  = 0;
  int n_pass = 0;

  assign mem_dout_a = rom[mem_addr_a];
  assign mem_dout_z = rom[mem_addr_z];

  wire [27:0] vec_a = {busy_a, valid_a, done_a, mem_addr_a, data_a, count_a};
  wire [27:0] vec_z = {busy_z, valid_z, done_z, mem_addr_z, data_z, count_z};

  text_fetch_ctrl #(.DWELL_CYC(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .start_addr(start_addr),
    .pause(pause), .mem_addr(mem_addr_a), .mem_dout(mem_dout_a),
    .char_valid(valid_a), .char_data(data_a), .char_ready(char_ready),
    .busy(busy_a), .done(done_a), .char_count(count_a)
  );

  text_fetch_ctrl #(.DWELL_CYC(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .start(start_z), .start_addr(start_addr),
    .pause(pause), .mem_addr(mem_addr_z), .mem_dout(mem_dout_z),
    .char_valid(valid_z), .char_data(data_z), .char_ready(char_ready),
    .busy(busy_z), .done(done_z), .char_count(count_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h (busy,valid,done,addr,data,count)", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic check_dut(input string tag, input bit z, input bit b, input bit v, input bit d);
    check_eq(tag, z ? vec_z : vec_a, {b, v, d, m_addr[z], m_data[z], m_cnt[z]});
  endtask

  // Random start pulses while busy must be ignored; start_addr churns too.
  task automatic stray(input bit z);
    logic s;
    s = ($urandom_range(0, 3) == 0);
    if (z) start_z = s; else start_a = s;
    start_addr = 8'($urandom);
  endtask

  task automatic finish_seq(input bit z);
    check_dut("done", z, 1'b1, 1'b0, 1'b1);
    stray(z);
    @(negedge clk);
    start_a = 1'b0;
    start_z = 1'b0;
    check_dut("idle", z, 1'b0, 1'b0, 1'b0);
  endtask

  // One start-to-idle sequence; expected timing follows from the ROM text,
  // the ready/pause choices and the dwell length.
  task automatic run(input bit z, input logic [7:0] sa, input int rdy_pct,
                     input int pause_pct, input int hold);
    int         dw;
    int         rem;
    bit         r, p, ex;
    logic [7:0] a;
    dw = z ? 0 : 4;
    start_addr = sa;
    pause      = 1'($urandom);
    char_ready = 1'($urandom);
    if (z) start_z = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_z = 1'b0;
    start_addr = 8'($urandom);
    a = sa;
    m_addr[z] = sa;
    m_cnt[z]  = 9'd0;
    for (int k = 0; k < 300; k++) begin
      check_dut("fetch", z, 1'b1, 1'b0, 1'b0);
      stray(z);
      @(negedge clk);
      if (rom[a] == 8'h00) begin
        finish_seq(z);
        return;
      end
      m_data[z] = rom[a];
      r = 1'b0;
      for (int j = 0; j < 200 && !r; j++) begin
        check_dut("present", z, 1'b1, 1'b1, 1'b0);
        r = ((j >= hold) && ($urandom_range(1, 100) <= rdy_pct)) || (j == 199);
        char_ready = r;
        pause = 1'($urandom);
        stray(z);
        @(negedge clk);
      end
      m_cnt[z] = m_cnt[z] + 9'd1;
      rem = dw;
      ex  = 1'b0;
      for (int j = 0; j < 100 && !ex; j++) begin
        check_dut("dwell", z, 1'b1, 1'b0, 1'b0);
        p = (j < 50) && ($urandom_range(1, 100) <= pause_pct);
        pause = p;
        char_ready = 1'($urandom);
        stray(z);
        @(negedge clk);
        ex = (dw == 0) || (!p && rem == 1);
        if (!p && rem > 0) rem--;
      end
      if (a == 8'hFF) begin
        finish_seq(z);
        return;
      end
      a = a + 8'd1;
      m_addr[z] = a;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sa, len;
    rst_n = 1'b0;
    start_a = 1'b0;
    start_z = 1'b0;
    start_addr = 8'h00;
    pause = 1'b0;
    char_ready = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h20;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 8'h00;
      m_data[i] = 8'h00;
      m_cnt[i]  = 9'd0;
    end
    #23;
    check_eq("reset_a", vec_a, 28'h0);
    check_eq("reset_z", vec_z, 28'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    rom[0] = 8'h48; rom[1] = 8'h49; rom[2] = 8'h00;
    run(1'b0, 8'h00, 100, 0, 0);
    run(1'b0, 8'h00, 100, 30, 5);
    run(1'b1, 8'h00, 100, 0, 0);

    rom[8'hFE] = 8'h41; rom[8'hFF] = 8'h42;
    run(1'b0, 8'hFE, 100, 0, 0);
    run(1'b1, 8'hFE, 70, 40, 1);

    rom[8'h10] = 8'h00;
    run(1'b0, 8'h10, 100, 0, 0);

    // Asynchronous reset while the first cell is dwelling.
    start_addr = 8'h00;
    char_ready = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset_a", vec_a, 28'h0);
    check_eq("async_reset_z", vec_z, 28'h0);
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 8'h00;
      m_data[i] = 8'h00;
      m_cnt[i]  = 9'd0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b0, 8'h00, 100, 0, 0);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(1, 255));
      sa  = $urandom_range(0, 255);
      if (t % 6 == 5) sa = $urandom_range(236, 255);
      len = $urandom_range(0, 20);
      if (sa + len <= 255) rom[sa + len] = 8'h00;
      run(1'($urandom), 8'(sa), $urandom_range(30, 100), $urandom_range(0, 60),
          $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
